// File: rtl/param_alu_processor.sv
// WIDTH-bit, 2^RADDR-register load/move/ALU/store engine: two-stage pipeline with
// E2->E1 operand forwarding. Carry/zero flags are built only when PROC_FLAGS_EN is defined.
module param_alu_processor #(
  parameter int WIDTH = 8,
  parameter int RADDR = 3
) (
  input  logic                 clock,
  input  logic                 resetN,
  input  logic                 funcValid,
  input  logic [3+2*RADDR-1:0] func,
  input  logic [WIDTH-1:0]     dataIn,
  output logic [WIDTH-1:0]     dataOut,
  output logic                 dataOutValid,
  output logic [1:0]           flags
);
  localparam int NREG = 1 << RADDR;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_MOVE  = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_AND   = 3'd4,
    OP_OR    = 3'd5,
    OP_XOR   = 3'd6,
    OP_STORE = 3'd7
  } op_e;

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  op_e              opc_p1_q, opc_p1_d;
  logic [RADDR-1:0] rd_p1_q, rd_p1_d;
  logic [WIDTH-1:0] a_p1_q, a_p1_d;
  logic [WIDTH-1:0] b_p1_q, b_p1_d;
  logic             vld_p1_q, vld_p1_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvld_q, dvld_d;

  op_e              op_in;
  logic [RADDR-1:0] rd_in, rs_in;
  logic [WIDTH-1:0] res_p2;
  logic             wr_p2;

  function automatic logic [WIDTH-1:0] alu_f(input op_e op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (op)
      OP_LOAD, OP_MOVE: alu_f = b;
      OP_ADD:           alu_f = a + b;
      OP_SUB:           alu_f = a - b;
      OP_AND:           alu_f = a & b;
      OP_OR:            alu_f = a | b;
      OP_XOR:           alu_f = a ^ b;
      default:          alu_f = a;
    endcase
  endfunction

  assign op_in  = op_e'(func[3+2*RADDR-1 -: 3]);
  assign rd_in  = func[2*RADDR-1 -: RADDR];
  assign rs_in  = func[RADDR-1:0];
  assign res_p2 = alu_f(opc_p1_q, a_p1_q, b_p1_q);
  assign wr_p2  = vld_p1_q && (opc_p1_q != OP_STORE);

  // ---- E1: issue and operand fetch, taking E2's result when it targets the same register
  always_comb begin
    vld_p1_d = funcValid;
    opc_p1_d = opc_p1_q;
    rd_p1_d  = rd_p1_q;
    a_p1_d   = a_p1_q;
    b_p1_d   = b_p1_q;
    if (funcValid) begin
      opc_p1_d = op_in;
      rd_p1_d  = rd_in;
      a_p1_d   = (wr_p2 && rd_p1_q == rd_in) ? res_p2 : regs_q[rd_in];
      if (op_in == OP_LOAD) b_p1_d = dataIn;
      else                  b_p1_d = (wr_p2 && rd_p1_q == rs_in) ? res_p2 : regs_q[rs_in];
    end
  end

  // ---- E2: execute and write back to the register file or the output port
  always_comb begin
    regs_d = regs_q;
    dout_d = dout_q;
    dvld_d = 1'b0;
    if (wr_p2) regs_d[rd_p1_q] = res_p2;
    if (vld_p1_q && opc_p1_q == OP_STORE) begin
      dout_d = res_p2;
      dvld_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      opc_p1_q <= OP_LOAD;
      rd_p1_q  <= '0;
      a_p1_q   <= '0;
      b_p1_q   <= '0;
      vld_p1_q <= 1'b0;
      dout_q   <= '0;
      dvld_q   <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      opc_p1_q <= opc_p1_d;
      rd_p1_q  <= rd_p1_d;
      a_p1_q   <= a_p1_d;
      b_p1_q   <= b_p1_d;
      vld_p1_q <= vld_p1_d;
      dout_q   <= dout_d;
      dvld_q   <= dvld_d;
    end
  end

  assign dataOut      = dout_q;
  assign dataOutValid = dvld_q;

`ifdef PROC_FLAGS_EN
  logic [1:0] flags_q, flags_d;
  logic       carry_p2;

  // Unsigned overflow of the wrapped sum shows up as the sum falling below an addend.
  always_comb begin
    carry_p2 = (opc_p1_q == OP_ADD) ? (res_p2 < a_p1_q) : (a_p1_q < b_p1_q);
    flags_d  = flags_q;
    if (vld_p1_q) begin
      case (opc_p1_q)
        OP_ADD, OP_SUB:         flags_d = {carry_p2, res_p2 == '0};
        OP_AND, OP_OR, OP_XOR:  flags_d = {1'b0, res_p2 == '0};
        default:                flags_d = flags_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) flags_q <= 2'b00;
    else         flags_q <= flags_d;
  end

  assign flags = flags_q;
`else
  assign flags = 2'b00;
`endif

endmodule

// File: tb/tb_param_alu_processor.sv
// Self-checking bench for param_alu_processor (WIDTH=8, RADDR=3): vector table plus
// hand-written bubble and reset sequences; STORE results are scoreboarded by due edge.
module tb_param_alu_processor;
  localparam logic [2:0] LD = 3'd0, MV = 3'd1, AD = 3'd2, SB = 3'd3,
                         AN = 3'd4, OR = 3'd5, XR = 3'd6, ST = 3'd7;

  logic       clock;
  logic       resetN;
  logic       funcValid;
  logic [8:0] func;
  logic [7:0] dataIn;
  logic [7:0] dataOut;
  logic       dataOutValid;
  logic [1:0] flags;

  param_alu_processor #(.WIDTH(8), .RADDR(3)) dut (
    .clock(clock), .resetN(resetN), .funcValid(funcValid), .func(func),
    .dataIn(dataIn), .dataOut(dataOut), .dataOutValid(dataOutValid), .flags(flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [7:0] din;
    logic [7:0] ed;
    logic [1:0] ef;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] d;
    logic [1:0] f;
  } sb_t;

  vec_t       tbl[$];
  sb_t        sbq[$];
  int         checks = 0;
  int         errors = 0;
  int         ecnt = 0;
  logic       rst_edge = 1'b0;
  logic [7:0] exp_dout = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge %0d: actual=%0h required=%0h", nm, ecnt, act, req);
    end
  endtask

  always @(posedge clock) begin
    ecnt++;
    rst_edge = !resetN;
  end

  always @(negedge clock) begin
    if (ecnt > 0) begin
      if (rst_edge) begin
        chk("rst_valid", {31'd0, dataOutValid}, 32'd0);
        chk("rst_dout", {24'd0, dataOut}, 32'd0);
        chk("rst_flags", {30'd0, flags}, 32'd0);
        exp_dout = 8'h00;
      end else if (sbq.size() > 0 && sbq[0].due == ecnt) begin
        chk("store_valid", {31'd0, dataOutValid}, 32'd1);
        chk("store_dout", {24'd0, dataOut}, {24'd0, sbq[0].d});
        chk("store_flags", {30'd0, flags}, {30'd0, sbq[0].f});
        exp_dout = sbq[0].d;
        void'(sbq.pop_front());
      end else begin
        chk("idle_valid", {31'd0, dataOutValid}, 32'd0);
        chk("idle_dout", {24'd0, dataOut}, {24'd0, exp_dout});
      end
    end
  end

  // Inputs change 1 time unit after an edge and are sampled at the next one;
  // a STORE sampled at edge j+1 shows its result after edge j+2.
  task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] rs, input logic [7:0] din,
                       input logic [7:0] ed, input logic [1:0] ef);
    sb_t e;
    @(posedge clock);
    #1;
    funcValid = v;
    func      = {op, rd, rs};
    dataIn    = din;
    if (v && op == ST) begin
      e.due = ecnt + 2;
      e.d   = ed;
`ifdef PROC_FLAGS_EN
      e.f   = ef;
`else
      e.f   = 2'b00;
`endif
      sbq.push_back(e);
    end
  endtask

  initial begin
    resetN    = 1'b0;
    funcValid = 1'b0;
    func      = '0;
    dataIn    = '0;

    tbl.push_back('{LD, 3'd1, 3'd0, 8'd10,  8'd0,   2'b00});
    tbl.push_back('{LD, 3'd0, 3'd0, 8'd5,   8'd0,   2'b00});
    tbl.push_back('{XR, 3'd0, 3'd1, 8'd0,   8'd0,   2'b00});
    tbl.push_back('{ST, 3'd0, 3'd0, 8'd0,   8'd15,  2'b00});
    tbl.push_back('{LD, 3'd2, 3'd0, 8'd1,   8'd0,   2'b00});
    tbl.push_back('{AD, 3'd2, 3'd2, 8'd0,   8'd0,   2'b00});
    tbl.push_back('{AD, 3'd2, 3'd2, 8'd0,   8'd0,   2'b00});
    tbl.push_back('{ST, 3'd2, 3'd0, 8'd0,   8'd4,   2'b00});
    tbl.push_back('{LD, 3'd3, 3'd0, 8'd200, 8'd0,   2'b00});
    tbl.push_back('{LD, 3'd4, 3'd0, 8'd100, 8'd0,   2'b00});
    tbl.push_back('{AD, 3'd3, 3'd4, 8'd0,   8'd0,   2'b00});
    tbl.push_back('{ST, 3'd3, 3'd0, 8'd0,   8'd44,  2'b10});
    tbl.push_back('{SB, 3'd3, 3'd3, 8'd0,   8'd0,   2'b00});
    tbl.push_back('{ST, 3'd3, 3'd0, 8'd0,   8'd0,   2'b01});
    tbl.push_back('{LD, 3'd5, 3'd0, 8'd3,   8'd0,   2'b00});
    tbl.push_back('{LD, 3'd6, 3'd0, 8'd5,   8'd0,   2'b00});
    tbl.push_back('{SB, 3'd5, 3'd6, 8'd0,   8'd0,   2'b00});
    tbl.push_back('{ST, 3'd5, 3'd0, 8'd0,   8'd254, 2'b10});
    tbl.push_back('{LD, 3'd1, 3'd0, 8'hF0,  8'd0,   2'b00});
    tbl.push_back('{LD, 3'd2, 3'd0, 8'h3C,  8'd0,   2'b00});
    tbl.push_back('{AN, 3'd1, 3'd2, 8'd0,   8'd0,   2'b00});
    tbl.push_back('{ST, 3'd1, 3'd0, 8'd0,   8'h30,  2'b00});
    tbl.push_back('{OR, 3'd2, 3'd1, 8'd0,   8'd0,   2'b00});
    tbl.push_back('{ST, 3'd2, 3'd0, 8'd0,   8'h3C,  2'b00});
    tbl.push_back('{MV, 3'd6, 3'd2, 8'd0,   8'd0,   2'b00});
    tbl.push_back('{ST, 3'd6, 3'd0, 8'd0,   8'h3C,  2'b00});
    tbl.push_back('{ST, 3'd1, 3'd0, 8'd0,   8'h30,  2'b00});
    tbl.push_back('{XR, 3'd4, 3'd4, 8'd0,   8'd0,   2'b00});
    tbl.push_back('{ST, 3'd4, 3'd0, 8'd0,   8'd0,   2'b01});
    tbl.push_back('{LD, 3'd0, 3'd0, 8'h80,  8'd0,   2'b00});
    tbl.push_back('{LD, 3'd7, 3'd0, 8'h80,  8'd0,   2'b00});
    tbl.push_back('{AD, 3'd0, 3'd7, 8'd0,   8'd0,   2'b00});
    tbl.push_back('{ST, 3'd0, 3'd0, 8'd0,   8'd0,   2'b11});
    tbl.push_back('{LD, 3'd0, 3'd0, 8'd1,   8'd0,   2'b00});
    tbl.push_back('{ST, 3'd0, 3'd0, 8'd0,   8'd1,   2'b11});
    tbl.push_back('{AN, 3'd0, 3'd0, 8'd0,   8'd0,   2'b00});
    tbl.push_back('{ST, 3'd0, 3'd0, 8'd0,   8'd1,   2'b00});
    tbl.push_back('{LD, 3'd3, 3'd0, 8'd7,   8'd0,   2'b00});
    tbl.push_back('{LD, 3'd3, 3'd0, 8'd8,   8'd0,   2'b00});
    tbl.push_back('{ST, 3'd3, 3'd0, 8'd0,   8'd8,   2'b00});

    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;

    foreach (tbl[i])
      drive(1'b1, tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].din, tbl[i].ed, tbl[i].ef);

    // Bubbles carrying a STORE and junk data must not touch any state.
    drive(1'b1, LD, 3'd7, 3'd0, 8'd9, 8'd0, 2'b00);
    repeat (3) drive(1'b0, ST, 3'd7, 3'd0, 8'h55, 8'd0, 2'b00);
    drive(1'b1, ST, 3'd7, 3'd0, 8'h00, 8'd9, 2'b00);

    // Set both flags, then reset with a LOAD still in E1 and another presented in the reset cycle.
    drive(1'b1, LD, 3'd1, 3'd0, 8'hFF, 8'd0, 2'b00);
    drive(1'b1, LD, 3'd2, 3'd0, 8'd1,  8'd0, 2'b00);
    drive(1'b1, AD, 3'd1, 3'd2, 8'd0,  8'd0, 2'b00);
    drive(1'b1, ST, 3'd1, 3'd0, 8'd0,  8'd0, 2'b11);
    drive(1'b1, LD, 3'd7, 3'd0, 8'd9,  8'd0, 2'b00);
    @(posedge clock);
    #1;
    resetN    = 1'b0;
    funcValid = 1'b1;
    func      = {LD, 3'd7, 3'd0};
    dataIn    = 8'h33;
    @(posedge clock);
    #1 resetN = 1'b1;
    funcValid = 1'b0;
    drive(1'b1, ST, 3'd7, 3'd0, 8'd0, 8'd0, 2'b00);
    drive(1'b1, ST, 3'd1, 3'd0, 8'd0, 8'd0, 2'b00);
    repeat (3) drive(1'b0, LD, 3'd0, 3'd0, 8'd0, 8'd0, 2'b00);

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clock);
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: actual=%0d pending stores required=0", sbq.size());
    end
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
